maze_move_ctrl: RTL

- Single-clock controller for the 5x5 maze game.
- Owns the player position registers (col, row) and sequences all moves from four direction buttons.
- Arbitrates simultaneous presses and checks every target cell against a wall map.
- Handles wall hits (penalty, return to start), detects the goal (accept), and counts moves.
- Replaces the per-button ripple-clocked counters with one synchronous state machine.

---
 rtl/maze_move_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/maze_move_ctrl.sv
// Move sequencer for the 5x5 maze game.
// Owns the player position and handles walls, penalties, goal and the move count.
module maze_move_ctrl #(
  parameter logic [24:0] WALL_MAP   = 25'h130694A,
  parameter int          GOAL_ROW   = 1,
  parameter int          GOAL_COL   = 2,
  parameter int          HIT_CYCLES = 4,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [2:0]       col,
  output logic [2:0]       row,
  output logic             hit,
  output logic             accept,
  output logic [CNT_W-1:0] move_cnt,
  output logic [1:0]       state
);

  localparam int TW = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_WIN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_col;
  logic [2:0]       r_row;
  logic             r_hit;
  logic             r_accept;
  logic [CNT_W-1:0] r_cnt;
  logic [TW-1:0]    r_timer;
  logic [3:0]       r_hist;

  logic [3:0]       w_btn;
  logic [3:0]       w_press;
  logic             w_go;
  logic [2:0]       w_tcol;
  logic [2:0]       w_trow;
  logic [4:0]       w_idx;
  logic             w_wall;
  logic             w_goal;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_btn   = {btn_up, btn_down, btn_left, btn_right};
  assign w_press = w_btn & ~r_hist;

  // Fixed priority up > down > left > right; w_go drops for off-grid targets.
  always_comb begin
    w_go   = 1'b0;
    w_tcol = r_col;
    w_trow = r_row;
    if (w_press[3]) begin
      w_go   = (r_row != 3'd0);
      w_trow = r_row - 3'd1;
    end else if (w_press[2]) begin
      w_go   = (r_row != 3'd4);
      w_trow = r_row + 3'd1;
    end else if (w_press[1]) begin
      w_go   = (r_col != 3'd0);
      w_tcol = r_col - 3'd1;
    end else if (w_press[0]) begin
      w_go   = (r_col != 3'd4);
      w_tcol = r_col + 3'd1;
    end
  end

  assign w_idx  = 5'(w_trow) * 5'd5 + 5'(w_tcol);
  assign w_wall = (w_idx < 5'd25) && WALL_MAP[w_idx];
  assign w_goal = (w_trow == 3'(GOAL_ROW)) && (w_tcol == 3'(GOAL_COL));

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_col    <= 3'd0;
      r_row    <= 3'd0;
      r_hit    <= 1'b0;
      r_accept <= 1'b0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_hist   <= 4'd0;
    end else begin
      r_hist <= w_btn;
      if (restart) begin
        r_state  <= S_PLAY;
        r_col    <= 3'd0;
        r_row    <= 3'd0;
        r_hit    <= 1'b0;
        r_accept <= 1'b0;
        r_cnt    <= '0;
        r_timer  <= '0;
      end else begin
        unique case (r_state)
          S_PLAY: begin
            if (w_go) begin
              r_cnt <= w_cnt_inc;
              if (w_goal) begin
                r_col    <= w_tcol;
                r_row    <= w_trow;
                r_accept <= 1'b1;
                r_state  <= S_WIN;
              end else if (w_wall) begin
                r_col   <= 3'd0;
                r_row   <= 3'd0;
                r_hit   <= 1'b1;
                r_timer <= TW'(HIT_CYCLES - 1);
                r_state <= S_HIT;
              end else begin
                r_col <= w_tcol;
                r_row <= w_trow;
              end
            end
          end
          S_HIT: begin
            if (r_timer == '0) begin
              r_hit   <= 1'b0;
              r_state <= S_PLAY;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          S_WIN: begin
            r_accept <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign col      = r_col;
  assign row      = r_row;
  assign hit      = r_hit;
  assign accept   = r_accept;
  assign move_cnt = r_cnt;
  assign state    = r_state;

endmodule
